// File: rtl/halflife_pkg.sv
// Shared types for the halflife decay controller: FSM states and the
// counter command encoding in {rst,up,down,load} order.
package halflife_pkg;

    localparam int DEF_N = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WAIT,
        HALVE,
        DONE,
        ABORT
    } state_t;

    localparam logic [3:0] CMD_RST  = 4'b1000;
    localparam logic [3:0] CMD_UP   = 4'b0100;
    localparam logic [3:0] CMD_DOWN = 4'b0010;
    localparam logic [3:0] CMD_LOAD = 4'b0001;
    localparam logic [3:0] CMD_HOLD = 4'b0000;

endpackage

// File: rtl/halflife_ctrl_prescaler.sv
// Half-life period prescaler: counts while enabled, tick marks the last
// cycle of the period.
module hl_prescaler #(
    parameter int PERIOD = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tick = (count == W'(PERIOD - 1));

endmodule

// File: rtl/halflife_ctrl.sv
// Decay sequencer: loads an initial value into the external up/down/load
// counter, then halves it once per PERIOD cycles until it reaches zero.
//
//   state | meaning
//   IDLE  | waiting for start
//   LOAD  | counter being loaded with the initial value
//   WAIT  | half-life period elapsing
//   HALVE | counter being loaded with its value shifted right by one
//   DONE  | run finished normally, one-cycle done pulse
//   ABORT | run cancelled, counter being reset
module halflife_ctrl
    import halflife_pkg::*;
#(
    parameter int N      = DEF_N,
    parameter int PERIOD = 16,
    parameter int HW     = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [N-1:0]  init_val,
    input  logic [N-1:0]  cnt_val,
    output logic          cnt_rst,
    output logic          cnt_up,
    output logic          cnt_down,
    output logic          cnt_load,
    output logic [N-1:0]  cnt_in,
    output logic          busy,
    output logic          done,
    output logic [HW-1:0] halvings
);

    state_t       state;
    state_t       state_nx;
    logic [3:0]   cmd;
    logic [3:0]   cmd_nx;
    logic [N-1:0] load_nx;
    logic         tick;

    hl_prescaler #(.PERIOD(PERIOD)) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .clr  (state != WAIT),
        .en   (state == WAIT),
        .tick (tick)
    );

    // In LOAD and HALVE, cnt_in holds the value just sent to the counter,
    // so it decides whether the decay has reached zero.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:        if (start) state_nx = LOAD;
            LOAD, HALVE: begin
                if (abort)              state_nx = ABORT;
                else if (cnt_in == '0)  state_nx = DONE;
                else                    state_nx = WAIT;
            end
            WAIT: begin
                if (abort)     state_nx = ABORT;
                else if (tick) state_nx = HALVE;
            end
            DONE, ABORT: state_nx = IDLE;
            default:     state_nx = IDLE;
        endcase
    end

    always_comb begin
        cmd_nx  = CMD_HOLD;
        load_nx = '0;
        case (state_nx)
            LOAD: begin
                cmd_nx  = CMD_LOAD;
                load_nx = init_val;
            end
            HALVE: begin
                cmd_nx  = CMD_LOAD;
                load_nx = cnt_val >> 1;
            end
            ABORT:   cmd_nx = CMD_RST;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cmd      <= CMD_HOLD;
            cnt_in   <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            halvings <= '0;
        end else begin
            state  <= state_nx;
            cmd    <= cmd_nx;
            cnt_in <= load_nx;
            busy   <= (state_nx != IDLE);
            done   <= (state_nx == DONE);
            if (state == IDLE && start) begin
                halvings <= '0;
            end else if (state_nx == HALVE && halvings != '1) begin
                halvings <= halvings + 1'b1;
            end
        end
    end

    assign {cnt_rst, cnt_up, cnt_down, cnt_load} = cmd;

endmodule

// File: tb/tb_halflife_ctrl.sv
// Bench for halflife_ctrl: drives it against a model up/down/load counter
// and compares every cycle with an arithmetic trace of the decay run.
module tb_halflife_ctrl;

    localparam int P    = 4;
    localparam int MAXC = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [3:0] init_val;
    logic [3:0] cnt_val;
    logic       cnt_rst, cnt_up, cnt_down, cnt_load;
    logic [3:0] cnt_in;
    logic       busy, done;
    logic [3:0] halvings;

    logic       wr_en = 1'b0;
    logic [3:0] wr_val = '0;
    logic [3:0] ctr = '0;

    int checks = 0;
    int errors = 0;

    logic       e_load [MAXC];
    logic       e_rst  [MAXC];
    logic       e_done [MAXC];
    logic       e_busy [MAXC];
    logic [3:0] e_in   [MAXC];
    logic [3:0] e_hv   [MAXC];

    halflife_ctrl #(.N(4), .PERIOD(P), .HW(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .init_val (init_val),
        .cnt_val  (cnt_val),
        .cnt_rst  (cnt_rst),
        .cnt_up   (cnt_up),
        .cnt_down (cnt_down),
        .cnt_load (cnt_load),
        .cnt_in   (cnt_in),
        .busy     (busy),
        .done     (done),
        .halvings (halvings)
    );

    always #5 clk = ~clk;

    // External counter; wr_en models another master writing it.
    always @(posedge clk) begin
        if (cnt_rst)       ctr <= '0;
        else if (cnt_up)   ctr <= ctr + 1'b1;
        else if (cnt_down) ctr <= ctr - 1'b1;
        else if (cnt_load) ctr <= cnt_in;
        else if (wr_en)    ctr <= wr_val;
    end
    assign cnt_val = ctr;

    // Expected trace, cycle 1 = first cycle after the start edge.
    // Returns the final busy cycle (DONE or ABORT).
    function automatic int build_model(int init, int ab, int wc, int wv);
        int cur, c, h, hv, last;
        for (int i = 0; i < MAXC; i++) begin
            e_load[i] = 0; e_rst[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            e_in[i] = '0; e_hv[i] = '0;
        end
        cur = init; c = 1; hv = 0;
        e_load[1] = 1; e_in[1] = 4'(init);
        while (1) begin
            h = c + P + 1;
            if (ab == c) begin e_rst[c+1] = 1; last = c + 1; break; end
            if (cur == 0) begin e_done[c+1] = 1; last = c + 1; break; end
            if (ab > c && ab < h) begin e_rst[ab+1] = 1; last = ab + 1; break; end
            if (wc > c && wc + 1 < h) cur = wv;
            cur = cur / 2;
            hv = (hv < 15) ? hv + 1 : 15;
            e_load[h] = 1; e_in[h] = 4'(cur);
            for (int k = h; k < MAXC; k++) e_hv[k] = 4'(hv);
            c = h;
        end
        for (int k = 1; k <= last; k++) e_busy[k] = 1;
        return last;
    endfunction

    task automatic test_reset();
        rst = 1; start = 1; abort = 0; init_val = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({cnt_rst, cnt_up, cnt_down, cnt_load, cnt_in, busy, done, halvings} !== 14'h0) begin
            errors++;
            $display("FAIL reset_outputs got=%h want=0", {cnt_rst, cnt_up, cnt_down, cnt_load, cnt_in, busy, done, halvings});
        end
        rst = 0; start = 0;
        @(posedge clk); #1;
        checks++;
        if ({cnt_load, cnt_rst, busy, done} !== 4'h0) begin
            errors++;
            $display("FAIL reset_idle got=%b want=0000", {cnt_load, cnt_rst, busy, done});
        end
    endtask

    task automatic test_decay(input int init, input int ab, input int wc, input int wv, input string nm);
        int last;
        logic [13:0] got, want;
        last = build_model(init, ab, wc, wv);
        init_val = 4'(init); start = 1;
        @(posedge clk); #1;
        start = 0;
        for (int c = 1; c <= last + 1; c++) begin
            abort = (c == ab);
            wr_en = (c == wc);
            wr_val = 4'(wv);
            got  = {cnt_rst, cnt_up, cnt_down, cnt_load, cnt_in, busy, done, halvings};
            want = {e_rst[c], 1'b0, 1'b0, e_load[c], e_in[c], e_busy[c], e_done[c], e_hv[c]};
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL %s cycle %0d outputs got=%h want=%h", nm, c, got, want);
            end
            if (c == last + 1) begin
                checks++;
                if (ctr !== ((wc == last) ? 4'(wv) : 4'd0)) begin
                    errors++;
                    $display("FAIL %s final_counter got=%0d want=%0d", nm, ctr, (wc == last) ? wv : 0);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        abort = 0; wr_en = 0;
    endtask

    task automatic test_reset_midrun();
        init_val = 4'd12; start = 1;
        @(posedge clk); #1;
        start = 0;
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if ({cnt_load, cnt_in, halvings} !== {1'b1, 4'd6, 4'd1}) begin
            errors++;
            $display("FAIL midrun_halve got=%h want=%h", {cnt_load, cnt_in, halvings}, {1'b1, 4'd6, 4'd1});
        end
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        checks++;
        if ({cnt_rst, cnt_up, cnt_down, cnt_load, cnt_in, busy, done, halvings} !== 14'h0) begin
            errors++;
            $display("FAIL midrun_reset got=%h want=0", {cnt_rst, cnt_up, cnt_down, cnt_load, cnt_in, busy, done, halvings});
        end
        init_val = 4'd5; start = 1;
        @(posedge clk); #1;
        start = 0;
        checks++;
        if ({cnt_load, cnt_in, busy} !== {1'b1, 4'd5, 1'b1}) begin
            errors++;
            $display("FAIL restart_load got=%h want=%h", {cnt_load, cnt_in, busy}, {1'b1, 4'd5, 1'b1});
        end
        repeat (5) begin @(posedge clk); #1; end
        checks++;
        if ({cnt_load, cnt_in, halvings} !== {1'b1, 4'd2, 4'd1}) begin
            errors++;
            $display("FAIL restart_halve got=%h want=%h", {cnt_load, cnt_in, halvings}, {1'b1, 4'd2, 4'd1});
        end
        abort = 1;
        @(posedge clk); #1;
        abort = 0;
        checks++;
        if ({cnt_rst, cnt_load, done} !== 3'b100) begin
            errors++;
            $display("FAIL abort_in_halve got=%b want=100", {cnt_rst, cnt_load, done});
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int last;
        last = build_model(8, -1, -1, 0);
        init_val = 4'd8; start = 1;
        @(posedge clk); #1;
        for (int c = 1; c <= last + 2; c++) begin
            if (c == last) begin
                checks++;
                if ({done, halvings} !== {1'b1, 4'd4}) begin
                    errors++;
                    $display("FAIL b2b_done got=%h want=%h", {done, halvings}, {1'b1, 4'd4});
                end
            end
            if (c == last + 1) begin
                checks++;
                if ({busy, cnt_load} !== 2'b00) begin
                    errors++;
                    $display("FAIL b2b_idle got=%b want=00", {busy, cnt_load});
                end
            end
            if (c < last + 2) begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if ({cnt_load, cnt_in, halvings, busy} !== {1'b1, 4'd8, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL b2b_reload got=%h want=%h", {cnt_load, cnt_in, halvings, busy}, {1'b1, 4'd8, 4'd0, 1'b1});
        end
        start = 0; abort = 1;
        @(posedge clk); #1;
        abort = 0;
        checks++;
        if ({cnt_rst, cnt_load, done} !== 3'b100) begin
            errors++;
            $display("FAIL abort_in_load got=%b want=100", {cnt_rst, cnt_load, done});
        end
        @(posedge clk); #1;
        checks++;
        if ({busy, cnt_rst} !== 2'b00) begin
            errors++;
            $display("FAIL abort_to_idle got=%b want=00", {busy, cnt_rst});
        end
    endtask

    initial begin
        int init, ab, wc, wv;
        test_reset();
        test_decay(12, -1, -1, 0, "decay12");
        test_decay(0, -1, -1, 0, "zero_init");
        test_decay(15, 8, -1, 0, "abort_wait");
        test_decay(14, -1, 3, 2, "ext_write");
        test_reset_midrun();
        test_back_to_back();
        for (int r = 0; r < 12; r++) begin
            init = $urandom_range(0, 15);
            ab   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 25) : -1;
            wc   = ($urandom_range(0, 1) == 0) ? $urandom_range(2, 20) : -1;
            wv   = $urandom_range(0, 15);
            test_decay(init, ab, wc, wv, "random");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
